// File: rtl/axi_basic_tx_arb.sv
// Two-requester round-robin arbiter in front of the TX pipeline. Ownership is
// packet-granular; the owner's stream passes through combinationally.
module axi_basic_tx_arb #(
    parameter int C_DATA_WIDTH = 64,
    parameter int STRB_WIDTH   = C_DATA_WIDTH / 8,
    parameter int C_MIN_BUF    = 1,
    parameter int TCQ          = 1
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    input  logic [C_DATA_WIDTH-1:0] s0_axis_tx_tdata,
    input  logic [STRB_WIDTH-1:0]   s0_axis_tx_tkeep,
    input  logic                    s0_axis_tx_tlast,
    input  logic [3:0]              s0_axis_tx_tuser,
    input  logic                    s0_axis_tx_tvalid,
    output logic                    s0_axis_tx_tready,
    input  logic [C_DATA_WIDTH-1:0] s1_axis_tx_tdata,
    input  logic [STRB_WIDTH-1:0]   s1_axis_tx_tkeep,
    input  logic                    s1_axis_tx_tlast,
    input  logic [3:0]              s1_axis_tx_tuser,
    input  logic                    s1_axis_tx_tvalid,
    output logic                    s1_axis_tx_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_tx_tdata,
    output logic [STRB_WIDTH-1:0]   m_axis_tx_tkeep,
    output logic                    m_axis_tx_tlast,
    output logic [3:0]              m_axis_tx_tuser,
    output logic                    m_axis_tx_tvalid,
    input  logic                    m_axis_tx_tready,
    input  logic [5:0]              trn_tbuf_av,
    input  logic                    trn_lnk_up,
    output logic [1:0]              arb_grant,
    output logic                    arb_busy
);

    // TCQ is kept only for interface compatibility; the RTL carries no delays.
    if (!(C_DATA_WIDTH == 64 || C_DATA_WIDTH == 128) || TCQ < 0) begin : g_bad_params
        $error("axi_basic_tx_arb: C_DATA_WIDTH must be 64 or 128");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [6:0] MIN_BUF = 7'(C_MIN_BUF);

    state_t state;
    logic   last_owner;
    logic   can_start;
    logic   sel0;
    logic   sel1;

    assign can_start = trn_lnk_up && ({1'b0, trn_tbuf_av} >= MIN_BUF);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: if (can_start) begin
                    // s0 wins on contention only if s1 owned last
                    if (s0_axis_tx_tvalid && (!s1_axis_tx_tvalid || last_owner)) begin
                        state      <= OWN0;
                        last_owner <= 1'b0;
                    end else if (s1_axis_tx_tvalid) begin
                        state      <= OWN1;
                        last_owner <= 1'b1;
                    end
                end
                OWN0: if (s0_axis_tx_tvalid && m_axis_tx_tready && s0_axis_tx_tlast)
                    state <= IDLE;
                OWN1: if (s1_axis_tx_tvalid && m_axis_tx_tready && s1_axis_tx_tlast)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Path is cut during reset so no beat is accepted while ownership is dropped.
    assign sel0 = (state == OWN0) && !user_rst;
    assign sel1 = (state == OWN1) && !user_rst;

    always_comb begin
        m_axis_tx_tdata   = '0;
        m_axis_tx_tkeep   = '0;
        m_axis_tx_tlast   = 1'b0;
        m_axis_tx_tuser   = '0;
        m_axis_tx_tvalid  = 1'b0;
        s0_axis_tx_tready = 1'b0;
        s1_axis_tx_tready = 1'b0;
        if (sel0) begin
            m_axis_tx_tdata   = s0_axis_tx_tdata;
            m_axis_tx_tkeep   = s0_axis_tx_tkeep;
            m_axis_tx_tlast   = s0_axis_tx_tlast;
            m_axis_tx_tuser   = s0_axis_tx_tuser;
            m_axis_tx_tvalid  = s0_axis_tx_tvalid;
            s0_axis_tx_tready = m_axis_tx_tready;
        end else if (sel1) begin
            m_axis_tx_tdata   = s1_axis_tx_tdata;
            m_axis_tx_tkeep   = s1_axis_tx_tkeep;
            m_axis_tx_tlast   = s1_axis_tx_tlast;
            m_axis_tx_tuser   = s1_axis_tx_tuser;
            m_axis_tx_tvalid  = s1_axis_tx_tvalid;
            s1_axis_tx_tready = m_axis_tx_tready;
        end
    end

    assign arb_grant = {state == OWN1, state == OWN0};
    assign arb_busy  = (state != IDLE);

endmodule

// File: doc/axi_basic_tx_arb.md
AXI_BASIC_TX_ARB -- requirements
Module: axi_basic_tx_arb

Interface
REQ-001 Parameters SHALL be: C_DATA_WIDTH, default 64, TX data width (64 or 128 only).
REQ-002 Parameters SHALL be: STRB_WIDTH, default C_DATA_WIDTH/8, tkeep width.
REQ-003 Parameters SHALL be: C_MIN_BUF, default 1, minimum trn_tbuf_av value required to start a packet.
REQ-004 Parameters SHALL be: TCQ, default 1, clock-to-Q delay.
REQ-005 Ports SHALL be, in this order:
- user_clk  in  1  sole clock, rising edge.
- user_rst  in  1  reset, synchronous, active-high.
- sN_axis_tx_tdata  in  C_DATA_WIDTH  requester N data (N=0,1).
- sN_axis_tx_tkeep  in  STRB_WIDTH  requester N byte enables.
- sN_axis_tx_tlast  in  1  requester N end of packet.
- sN_axis_tx_tuser  in  4  requester N user bits.
- sN_axis_tx_tvalid  in  1  requester N valid.
- sN_axis_tx_tready  out  1  requester N ready.
- m_axis_tx_tdata / tkeep / tlast / tuser  out  C_DATA_WIDTH / STRB_WIDTH / 1 / 4  to the TX pipeline.
- m_axis_tx_tvalid  out  1  to the TX pipeline.
- m_axis_tx_tready  in  1  from the TX pipeline.
- trn_tbuf_av  in  6  TX buffers available.
- trn_lnk_up  in  1  link up.
- arb_grant  out  2  one-hot current owner; 00 = none.
- arb_busy  out  1  a packet is in flight.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, OWN0, OWN1; the state register SHALL be the only arbitration state besides the round-robin pointer last_owner.
REQ-007 Start condition: in IDLE, arbitration SHALL occur only when trn_lnk_up=1 and trn_tbuf_av >= C_MIN_BUF.
- Requesting sN = sN_axis_tx_tvalid=1.
REQ-008 Round-robin: with both requesting, the requester not equal to last_owner SHALL win; with one requesting, that one SHALL win.
REQ-009 Transition IDLE->OWNn SHALL take effect on the next edge; last_owner SHALL update to n on that edge.
- Arbitration latency is one cycle from tvalid to tready eligibility.
REQ-010 In OWNn, the owner's path to the master port SHALL be combinational:
- m_axis_tx_* = sn_axis_tx_*.
- sn_axis_tx_tready = m_axis_tx_tready.
- The non-owner's tready SHALL be 0.
REQ-011 In IDLE, m_axis_tx_tvalid, m_axis_tx_tlast, both s*_tready and arb_grant SHALL be 0; m_axis_tx_tdata/tkeep/tuser SHALL be 0.
REQ-012 OWNn->IDLE SHALL occur on the edge where sn_tvalid & m_tready & sn_tlast are all 1.
- There SHALL be exactly one IDLE cycle between packets (no back-to-back switching).
REQ-013 Ownership SHALL be held until tlast regardless of:
- trn_lnk_up falling;
- trn_tbuf_av dropping;
- the other requester asserting;
- the owner deasserting tvalid mid-packet.
REQ-014 A single-beat packet (tlast on the first beat) SHALL be handled by REQ-012 with no special case.
REQ-015 arb_grant SHALL be 01 in OWN0 and 10 in OWN1; arb_busy SHALL be 1 in OWN0/OWN1 and 0 in IDLE; both are decoded from the state register only.
REQ-016 No data SHALL be buffered; the block SHALL add zero data latency and never reorder, drop or duplicate beats.

Reset
REQ-017 On user_rst=1 at a rising edge, state SHALL become IDLE and last_owner SHALL become 1 (so s0 wins the first contention).
- All outputs SHALL then take their REQ-011 values.
REQ-018 Reset asserted mid-packet SHALL abandon ownership immediately with no tlast generated; recovery of the truncated packet is the TX pipeline's concern.
REQ-019 While user_rst=1, no s*_tready SHALL assert.

Verification
REQ-020 Both tvalid=1 from reset, 3-beat packets, m_tready=1:
- s0 granted cycle 1, beats cycles 1-3, IDLE cycle 4;
- s1 granted cycle 5;
- grants alternate 0,1,0,1.
REQ-021 Only s1 requests for 4 consecutive packets: s1 wins every arbitration with one IDLE cycle between packets.
REQ-022 trn_tbuf_av=0 (C_MIN_BUF=1), s0 tvalid=1: no grant; set tbuf_av=5 -> arb_grant=01 on the next edge.
REQ-023 trn_lnk_up drops during beat 2 of a 4-beat s0 packet: s0 keeps the grant through tlast, then IDLE with no new grant until trn_lnk_up=1.
REQ-024 m_tready toggles 1,0,1,0 during an s1 packet: s1_tready mirrors m_tready, s0_tready stays 0, and the beat count out equals the beat count in.
REQ-025 user_rst pulsed on beat 2 of an s1 packet: arb_grant=00 on the next edge; the next contention is won by s0.
